// File: rtl/wand_bus_node_pkg.sv
// Shared definitions for the wired-AND bus node: FSM state codes and frame length.
// Build option: define PARITY_EN to add an even-parity bit after the payload.
package wand_bus_node_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Total bit-times on the line for one frame of data_w payload bits.
  function automatic int frame_bits(input int data_w);
`ifdef PARITY_EN
    return data_w + 3;
`else
    return data_w + 2;
`endif
  endfunction

endpackage

// File: rtl/wand_bus_node_if.sv
// Frame request/response and wired-AND line signals of one bus node.
// The node uses the slave modport; whoever feeds requests and the resolved net uses master.
interface wand_bus_node_if #(
  parameter int DATA_W = 8
) ();
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              bus_out;
  logic              bus_in;
  logic              tx_done;
  logic              arb_lost;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_err;

  modport master (
    output tx_valid, tx_data, bus_in,
    input  tx_ready, bus_out, tx_done, arb_lost, rx_valid, rx_data, rx_err
  );

  modport slave (
    input  tx_valid, tx_data, bus_in,
    output tx_ready, bus_out, tx_done, arb_lost, rx_valid, rx_data, rx_err
  );
endinterface

// File: rtl/wand_bus_node_sync.sv
// Two-flop synchronizer for the resolved wand net; resets to the released (high) level.
module wand_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_reg <= 2'b11;
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];
endmodule

// File: rtl/wand_bus_node.sv
// Wired-AND serial bus node: transmits with bitwise arbitration and receives every frame.
// Build option: PARITY_EN adds an even-parity bit, driven and arbitrated like a data bit.
module wand_bus_node
  import wand_bus_node_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BIT_TICKS = 16,
  parameter int IFS_BITS  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  wand_bus_node_if.slave bus
);
  localparam int TICK_W  = $clog2(BIT_TICKS);
  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int IFS_CYC = IFS_BITS * BIT_TICKS;
  localparam int IDLE_W  = $clog2(IFS_CYC + 1);

  localparam logic [TICK_W-1:0] TICK_SAMPLE = TICK_W'(BIT_TICKS / 2);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(BIT_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DATA_W - 1);
  localparam logic [IDLE_W-1:0] IDLE_FULL   = IDLE_W'(IFS_CYC);

  state_t              state_reg, state_next;
  logic [TICK_W-1:0]   tick_reg, tick_next;
  logic [BIT_W-1:0]    bit_idx_reg, bit_idx_next;
  logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
  logic [DATA_W-1:0]   tx_frame_reg, tx_frame_next;
  logic [DATA_W-1:0]   tx_shift_reg, tx_shift_next;
  logic [DATA_W-1:0]   rx_shift_reg, rx_shift_next;
  logic [DATA_W-1:0]   rx_data_reg, rx_data_next;
  logic                pend_reg, pend_next;
  logic                tx_active_reg, tx_active_next;
  logic                bus_out_reg, bus_out_next;
  logic                tx_done_reg, tx_done_next;
  logic                arb_lost_reg, arb_lost_next;
  logic                rx_valid_reg, rx_valid_next;
  logic                rx_err_reg, rx_err_next;
`ifdef PARITY_EN
  logic                rx_par_reg, rx_par_next;
`endif

  logic bus_s;
  logic sample;
  logic bit_end;
  logic line_idle;
  logic parity_ok;

  wand_bus_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.bus_in),
    .q     (bus_s)
  );

  assign sample    = (tick_reg == TICK_SAMPLE);
  assign bit_end   = (tick_reg == TICK_LAST);
  assign line_idle = (idle_cnt_reg == IDLE_FULL);

`ifdef PARITY_EN
  assign parity_ok = ((^rx_shift_reg) == rx_par_reg);
`else
  assign parity_ok = 1'b1;
`endif

  always_comb begin
    state_next     = state_reg;
    bit_idx_next   = bit_idx_reg;
    idle_cnt_next  = idle_cnt_reg;
    tx_frame_next  = tx_frame_reg;
    tx_shift_next  = tx_shift_reg;
    rx_shift_next  = rx_shift_reg;
    rx_data_next   = rx_data_reg;
    pend_next      = pend_reg;
    tx_active_next = tx_active_reg;
    bus_out_next   = bus_out_reg;
    tx_done_next   = 1'b0;
    arb_lost_next  = 1'b0;
    rx_valid_next  = 1'b0;
    rx_err_next    = 1'b0;
`ifdef PARITY_EN
    rx_par_next    = rx_par_reg;
`endif

    // Idle time only accumulates between frames, so every frame end forces a full refill.
    if (!bus_s || state_reg != IDLE) begin
      idle_cnt_next = '0;
    end else if (!line_idle) begin
      idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
    end

    if (bus.tx_valid && !pend_reg) begin
      pend_next     = 1'b1;
      tx_frame_next = bus.tx_data;
    end

    if (state_reg == IDLE || bit_end) begin
      tick_next = '0;
    end else begin
      tick_next = tick_reg + TICK_W'(1);
    end

    case (state_reg)
      IDLE: begin
        if (pend_reg && line_idle && bus_s) begin
          state_next     = START;
          tx_active_next = 1'b1;
          bus_out_next   = 1'b0;
        end else if (!bus_s) begin
          state_next     = START;
          tx_active_next = 1'b0;
          bus_out_next   = 1'b1;
        end
      end

      START: begin
        if (sample && bus_s) begin
          // Low pulse shorter than half a bit: not a real start.
          state_next     = IDLE;
          tx_active_next = 1'b0;
          bus_out_next   = 1'b1;
        end else if (bit_end) begin
          state_next    = DATA;
          bit_idx_next  = '0;
          tx_shift_next = tx_frame_reg;
          bus_out_next  = tx_active_reg ? tx_frame_reg[DATA_W-1] : 1'b1;
        end
      end

      DATA: begin
        if (sample) begin
          rx_shift_next = {rx_shift_reg[DATA_W-2:0], bus_s};
          if (tx_active_reg && tx_shift_reg[DATA_W-1] && !bus_s) begin
            arb_lost_next  = 1'b1;
            tx_active_next = 1'b0;
            bus_out_next   = 1'b1;
          end
        end
        if (bit_end) begin
          tx_shift_next = tx_shift_reg << 1;
          bit_idx_next  = bit_idx_reg + BIT_W'(1);
          if (bit_idx_reg == BIT_LAST) begin
`ifdef PARITY_EN
            state_next   = PARITY;
            bus_out_next = tx_active_reg ? (^tx_frame_reg) : 1'b1;
`else
            state_next   = STOP;
            bus_out_next = 1'b1;
`endif
          end else begin
            bus_out_next = tx_active_reg ? tx_shift_reg[DATA_W-2] : 1'b1;
          end
        end
      end

`ifdef PARITY_EN
      PARITY: begin
        if (sample) begin
          rx_par_next = bus_s;
          if (tx_active_reg && (^tx_frame_reg) && !bus_s) begin
            arb_lost_next  = 1'b1;
            tx_active_next = 1'b0;
            bus_out_next   = 1'b1;
          end
        end
        if (bit_end) begin
          state_next   = STOP;
          bus_out_next = 1'b1;
        end
      end
`endif

      STOP: begin
        if (sample) begin
          if (bus_s && parity_ok) begin
            rx_valid_next = 1'b1;
            rx_data_next  = rx_shift_reg;
            if (tx_active_reg) begin
              tx_done_next = 1'b1;
              pend_next    = 1'b0;
            end
          end else begin
            // A failed own frame keeps pend set and goes out again after the next IFS.
            rx_err_next = 1'b1;
          end
        end
        if (bit_end) begin
          state_next     = IDLE;
          tx_active_next = 1'b0;
          bus_out_next   = 1'b1;
        end
      end

      default: begin
        state_next     = IDLE;
        tx_active_next = 1'b0;
        bus_out_next   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      tick_reg      <= '0;
      bit_idx_reg   <= '0;
      idle_cnt_reg  <= '0;
      tx_frame_reg  <= '0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      pend_reg      <= 1'b0;
      tx_active_reg <= 1'b0;
      bus_out_reg   <= 1'b1;
      tx_done_reg   <= 1'b0;
      arb_lost_reg  <= 1'b0;
      rx_valid_reg  <= 1'b0;
      rx_err_reg    <= 1'b0;
`ifdef PARITY_EN
      rx_par_reg    <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      tick_reg      <= tick_next;
      bit_idx_reg   <= bit_idx_next;
      idle_cnt_reg  <= idle_cnt_next;
      tx_frame_reg  <= tx_frame_next;
      tx_shift_reg  <= tx_shift_next;
      rx_shift_reg  <= rx_shift_next;
      rx_data_reg   <= rx_data_next;
      pend_reg      <= pend_next;
      tx_active_reg <= tx_active_next;
      bus_out_reg   <= bus_out_next;
      tx_done_reg   <= tx_done_next;
      arb_lost_reg  <= arb_lost_next;
      rx_valid_reg  <= rx_valid_next;
      rx_err_reg    <= rx_err_next;
`ifdef PARITY_EN
      rx_par_reg    <= rx_par_next;
`endif
    end
  end

  assign bus.tx_ready = ~pend_reg;
  assign bus.bus_out  = bus_out_reg;
  assign bus.tx_done  = tx_done_reg;
  assign bus.arb_lost = arb_lost_reg;
  assign bus.rx_valid = rx_valid_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_err   = rx_err_reg;

endmodule

// File: tb/tb_wand_bus_node.sv
// Two wand_bus_node instances on one wand net plus a bench pull-down; scoreboard checks rx/tx events.
// With PARITY_EN defined the parity-bit scenarios are added.
module tb_wand_bus_node;
  import wand_bus_node_pkg::*;

  localparam int DW      = 8;
  localparam int BT      = 16;
  localparam int IFS     = 2;
  localparam int IFS_CYC = IFS * BT;
  localparam int NBITS   = frame_bits(DW);
  localparam int GAP     = 2 * IFS_CYC + 4 * BT;
  localparam int RX_ERR  = 256;

  logic clk = 1'b0;
  logic rst_n;
  logic force_n;

  always #5 clk = ~clk;

  wand_bus_node_if #(.DATA_W(DW)) if_a ();
  wand_bus_node_if #(.DATA_W(DW)) if_b ();

  wand net;
  assign net = if_a.bus_out;
  assign net = if_b.bus_out;
  assign net = force_n;
  assign if_a.bus_in = net;
  assign if_b.bus_in = net;

  wand_bus_node #(.DATA_W(DW), .BIT_TICKS(BT), .IFS_BITS(IFS)) node_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a)
  );

  wand_bus_node #(.DATA_W(DW), .BIT_TICKS(BT), .IFS_BITS(IFS)) node_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b)
  );

  int total = 0;
  int bad   = 0;

  // Expected events per node: kind 0 = rx (data or RX_ERR), 1 = tx_done (payload), 2 = arb_lost.
  int rxq0[$], rxq1[$], dnq0[$], dnq1[$], lq0[$], lq1[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic void push_ev(input int kind, input int n, input int v);
    case (kind)
      0: if (n == 0) rxq0.push_back(v); else rxq1.push_back(v);
      1: if (n == 0) dnq0.push_back(v); else dnq1.push_back(v);
      default: if (n == 0) lq0.push_back(v); else lq1.push_back(v);
    endcase
  endfunction

  function automatic int pop_ev(input int kind, input int n);
    int v = -1;
    case (kind)
      0: if (n == 0) begin if (rxq0.size() > 0) v = rxq0.pop_front(); end
         else begin if (rxq1.size() > 0) v = rxq1.pop_front(); end
      1: if (n == 0) begin if (dnq0.size() > 0) v = dnq0.pop_front(); end
         else begin if (dnq1.size() > 0) v = dnq1.pop_front(); end
      default: if (n == 0) begin if (lq0.size() > 0) v = lq0.pop_front(); end
               else begin if (lq1.size() > 0) v = lq1.pop_front(); end
    endcase
    return v;
  endfunction

  // Line level of bit k of a frame: start 0, payload MSB first, optional even parity, stop 1.
  function automatic int exp_frame_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 0;
    if (k <= DW) return int'(d[DW-k]);
`ifdef PARITY_EN
    if (k == DW + 1) return int'(^d);
`endif
    return 1;
  endfunction

  task automatic expect_single(input int n, input int d);
    push_ev(0, 0, d);
    push_ev(0, 1, d);
    push_ev(1, n, d);
  endtask

  // Simultaneous start: the smaller payload wins bitwise arbitration, loser retries afterwards.
  task automatic expect_both(input int da, input int db);
    int w;
    int l;
    int loser;
    if (da == db) begin
      push_ev(0, 0, da);
      push_ev(0, 1, da);
      push_ev(1, 0, da);
      push_ev(1, 1, db);
    end else begin
      w     = (da < db) ? da : db;
      l     = (da < db) ? db : da;
      loser = (da < db) ? 1 : 0;
      push_ev(0, 0, w);
      push_ev(0, 1, w);
      push_ev(0, 0, l);
      push_ev(0, 1, l);
      push_ev(1, 1 - loser, w);
      push_ev(1, loser, l);
      push_ev(2, loser, 1);
    end
  endtask

  task automatic mon_node(input int n, input logic rv, input logic re, input logic td,
                          input logic al, input logic [DW-1:0] rd);
    if (rv) begin
      $display("node%0d rx_valid data=%02h", n, rd);
      chk($sformatf("node%0d_rx_data", n), int'(rd), pop_ev(0, n));
    end
    if (re) begin
      $display("node%0d rx_err", n);
      chk($sformatf("node%0d_rx_err", n), RX_ERR, pop_ev(0, n));
    end
    if (td) begin
      $display("node%0d tx_done data=%02h", n, rd);
      chk($sformatf("node%0d_tx_done_data", n), int'(rd), pop_ev(1, n));
      chk($sformatf("node%0d_tx_done_with_rx_valid", n), int'(rv), 1);
    end
    if (al) begin
      $display("node%0d arb_lost", n);
      chk($sformatf("node%0d_arb_lost", n), 1, pop_ev(2, n));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_node(0, if_a.rx_valid, if_a.rx_err, if_a.tx_done, if_a.arb_lost, if_a.rx_data);
      mon_node(1, if_b.rx_valid, if_b.rx_err, if_b.tx_done, if_b.arb_lost, if_b.rx_data);
    end
  end

  task automatic send(input bit ua, input bit ub, input logic [DW-1:0] da, input logic [DW-1:0] db);
    @(negedge clk);
    $display("send a=%0b:%02h b=%0b:%02h", ua, da, ub, db);
    if_a.tx_valid = ua;
    if_a.tx_data  = da;
    if_b.tx_valid = ub;
    if_b.tx_data  = db;
    @(negedge clk);
    if_a.tx_valid = 1'b0;
    if_b.tx_valid = 1'b0;
  endtask

  // Returns at the negedge of the first cycle the net is low.
  task automatic wait_net_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (net === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL net_low_timeout: net=%0b required 0 within 2000 cycles", net);
    end
  endtask

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (if_a.tx_ready && if_b.tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL tx_ready_timeout: a=%0b b=%0b required 1", if_a.tx_ready, if_b.tx_ready);
    end
    repeat (GAP) @(negedge clk);
  endtask

  // Pull the net low around the mid-bit samples of frame bit k (both aligned and lagging receivers).
  task automatic force_bit(input int k);
    bit ok;
    wait_net_low(ok);
    if (ok) begin
      repeat (k * BT + 2) @(negedge clk);
      force_n = 1'b0;
      repeat (10) @(negedge clk);
      force_n = 1'b1;
    end
  endtask

  task automatic check_net_pattern(input logic [DW-1:0] d);
    bit ok;
    wait_net_low(ok);
    if (ok) begin
      for (int k = 0; k < NBITS; k++) begin
        repeat ((k == 0) ? BT / 2 : BT) @(negedge clk);
        chk($sformatf("net_bit%0d", k), int'(net), exp_frame_bit(d, k));
      end
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n         = 1'b0;
    force_n       = 1'b1;
    if_a.tx_valid = 1'b0;
    if_a.tx_data  = '0;
    if_b.tx_valid = 1'b0;
    if_b.tx_data  = '0;
    repeat (3) @(negedge clk);

    chk("rst_a_bus_out",  int'(if_a.bus_out),  1);
    chk("rst_a_tx_ready", int'(if_a.tx_ready), 1);
    chk("rst_a_rx_data",  int'(if_a.rx_data),  0);
    chk("rst_a_pulses",   int'({if_a.tx_done, if_a.arb_lost, if_a.rx_valid, if_a.rx_err}), 0);
    chk("rst_b_bus_out",  int'(if_b.bus_out),  1);
    chk("rst_b_tx_ready", int'(if_b.tx_ready), 1);
    chk("rst_b_rx_data",  int'(if_b.rx_data),  0);
    chk("rst_b_pulses",   int'({if_b.tx_done, if_b.arb_lost, if_b.rx_valid, if_b.rx_err}), 0);
    rst_n = 1'b1;

    // Single frame; line levels checked bit by bit.
    expect_single(0, 8'hA5);
    send(1'b1, 1'b0, 8'hA5, 8'h00);
    check_net_pattern(8'hA5);
    wait_quiet();

    // Same-cycle start, B loses, then retries.
    expect_both(8'h35, 8'h3C);
    send(1'b1, 1'b1, 8'h35, 8'h3C);
    repeat (4 * BT) @(negedge clk);
    chk("b_pending_during_arb", int'(if_b.tx_ready), 0);
    wait_quiet();

    // Framing error at STOP, then automatic resend.
    push_ev(0, 0, RX_ERR);
    push_ev(0, 1, RX_ERR);
    expect_single(0, 8'h5A);
    send(1'b1, 1'b0, 8'h5A, 8'h00);
    force_bit(NBITS - 1);
    wait_quiet();

    // Short glitch while idle: no event expected.
    force_n = 1'b0;
    repeat (3) @(negedge clk);
    force_n = 1'b1;
    wait_quiet();
    chk("glitch_a_tx_ready", int'(if_a.tx_ready), 1);

    // Reset in the middle of DATA discards the frame.
    send(1'b1, 1'b0, 8'hC3, 8'h00);
    wait_net_low(ok);
    repeat (4 * BT) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_a_bus_out",  int'(if_a.bus_out),  1);
    chk("midrst_a_tx_ready", int'(if_a.tx_ready), 1);
    chk("midrst_net",        int'(net),           1);
    rst_n = 1'b1;
    wait_quiet();

`ifdef PARITY_EN
    expect_single(0, 8'h07);
    send(1'b1, 1'b0, 8'h07, 8'h00);
    check_net_pattern(8'h07);
    wait_quiet();

    // Parity bit forced low: transmitter loses it, both see a parity error, then resend.
    push_ev(2, 0, 1);
    push_ev(0, 0, RX_ERR);
    push_ev(0, 1, RX_ERR);
    expect_single(0, 8'h07);
    send(1'b1, 1'b0, 8'h07, 8'h00);
    force_bit(DW + 1);
    wait_quiet();
`endif

    for (int it = 0; it < 20; it++) begin
      int mode;
      int n;
      logic [DW-1:0] da;
      logic [DW-1:0] db;
      mode = int'($urandom_range(0, 3));
      n    = int'($urandom_range(0, 1));
      da   = DW'($urandom);
      db   = DW'($urandom);
      case (mode)
        0: begin
          expect_single(0, int'(da));
          send(1'b1, 1'b0, da, db);
        end
        1: begin
          expect_single(1, int'(db));
          send(1'b0, 1'b1, da, db);
        end
        2: begin
          expect_both(int'(da), int'(db));
          send(1'b1, 1'b1, da, db);
        end
        default: begin
          push_ev(0, 0, RX_ERR);
          push_ev(0, 1, RX_ERR);
          expect_single(n, int'(da));
          send(n == 0, n == 1, da, da);
          force_bit(NBITS - 1);
        end
      endcase
      wait_quiet();
    end

    chk("left_rx_a",   rxq0.size(), 0);
    chk("left_rx_b",   rxq1.size(), 0);
    chk("left_done_a", dnq0.size(), 0);
    chk("left_done_b", dnq1.size(), 0);
    chk("left_lost_a", lq0.size(),  0);
    chk("left_lost_b", lq1.size(),  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
